load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store sequencer sitting directly upstream of the RV32I data memory (`dMem`). It accepts one memory request at a time from the execute stage over a valid/ready handshake and checks alignment and range. It drives the memory's write-enable, write-mode, address and data pins, then returns a sign- or zero-extended load result, or a store acknowledge, as a one-cycle response pulse.

## Interface
- `MEM_BYTES`, 1024: byte capacity of the attached data memory; legal byte addresses are 0..MEM_BYTES-1.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `reqValid` in 1: request present.
- `reqReady` out 1: unit can accept a request this cycle.
- `reqWrite` in 1: 1 = store, 0 = load.
- `reqFunct3` in 3: RV32I funct3 of the load/store instruction.
- `reqAddr` in 32: byte address.
- `reqWData` in 32: store data; the low bytes are used for SB/SH.
- `rspValid` out 1: one-cycle response pulse.
- `rspRData` out 32: extended load data; 0 for stores and errors.
- `rspErr` out 1: request rejected because of misalignment, out-of-range address or illegal funct3.
- `memWE` out 1: to `dMem` dMemWE.
- `memWMode` out 3: to `dMem` dMemWMode.
- `memAddr` out 32: to `dMem` address.
- `memWData` out 32: to `dMem` dataIn.
- `memRData` in 32: from `dMem` dataOut; registered, valid one edge after the address is presented with WE=0.

## Operation
- The handshake completes on a rising edge where `reqValid` and `reqReady` are both 1. All request fields are latched on that edge.
- `reqReady` = (state == IDLE). There is no response back-pressure: the consumer must take `rspValid` in the cycle it is asserted.
- FSM states:
  - IDLE: on handshake with an error, go to RESP. On a legal request, go to ACCESS. Otherwise stay.
  - ACCESS: `memAddr` = latched address. `memWE` = latched write. Next state is RESP for a store, LOADWAIT for a load.
  - LOADWAIT: `memWE` = 0, `memAddr` held. On the clock edge, capture the extended `memRData` into `rspRData`, then go to RESP.
  - RESP: `rspValid` = 1, then go to IDLE.
- Legal load funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Values 011, 110 and 111 are illegal.
- Legal store funct3 values: 000 SB, 001 SH, 010 SW. All other values are illegal.
- Misaligned accesses are errors: a halfword with addr[0]=1, or a word with addr[1:0]≠0.
- Range rule, checked on the full 32-bit address with no wrap-around:
  - A store of size S bytes is an error if addr > MEM_BYTES−S.
  - Every load is an error if addr > MEM_BYTES−4, because the memory always returns 4 bytes.
- An error request never asserts `memWE`. It produces RESP with `rspErr`=1 and `rspRData`=0.
- Store mapping onto `memWMode`: SB→3'b011, SH→3'b100, SW→3'b010. `memWData` = latched `reqWData` unmodified.
- Load extraction: `memRData[7:0]` is the byte at `addr`; memory data is little-endian.
  - LB: sign-extend bits [7:0]. LBU: zero-extend bits [7:0].
  - LH: sign-extend bits [15:0]. LHU: zero-extend bits [15:0].
  - LW: the full 32-bit word.
- `memWE` is 1 only in ACCESS with a latched store; it is 0 in every other state.

## Timing
- Load: handshake at edge E0; ACCESS during E0–E1; LOADWAIT during E1–E2; `rspValid` high during E2–E3; `reqReady` high again after E3. The next request is accepted no earlier than E3.
- Store: handshake at E0; `dMem` writes at E1; `rspValid` high during E1–E2; next request accepted no earlier than E2.
- Error: handshake at E0; `rspValid`=`rspErr`=1 during E0–E1.
- Reset values:
  - State IDLE.
  - `reqReady`=1.
  - `rspValid`=0, `rspErr`=0, `rspRData`=0.
  - `memWE`=0, `memWMode`=3'b010, `memAddr`=0, `memWData`=0.
- Reset mid-operation aborts the request with no response. `memWE` drops asynchronously with `rst` low, because it is decoded from the reset state.
- `reqValid` while not ready is ignored; the requester must hold its fields until the handshake completes.

## Structure
- `lsu_pkg` holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - dMem write-mode constants (WMODE_BU=3'b011, WMODE_HU=3'b100, WMODE_W=3'b010);
  - the FSM state encoding (IDLE, ACCESS, LOADWAIT, RESP).
- One combinational sub-module, `lsu_load_extend`, takes funct3 and a 32-bit word and returns the extended 32-bit result.
- The FSM, the request checks and the output registers stay in `load_store_unit`.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → `memWE` pulse with mode 010; load `rspRData`=0xDEADBEEF, `rspValid` three edges after the load handshake.
- SB 0x80 to 0x20 (preloaded 0), then LB 0x20 → 0xFFFFFF80; LBU 0x20 → 0x00000080.
- SH 0x8001 to 0x22, then LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001.
- LH at 0x21, SW at 0x12, LW at 0x3FD, funct3 011 → each gives `rspErr`=1 one edge after the handshake, `memWE` never asserted, `rspRData`=0.
- Back-to-back requests with `reqValid` held high → `reqReady` low during ACCESS/LOADWAIT/RESP; each request gets exactly one response, in order.
- `rst` low during ACCESS of a store → `memWE`=0 immediately, no `rspValid`, `reqReady`=1 after release, and the memory contents are unchanged by the aborted store.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
package lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // dMem write-mode pin encodings
    localparam logic [2:0] WMODE_BU = 3'b011;
    localparam logic [2:0] WMODE_HU = 3'b100;
    localparam logic [2:0] WMODE_W  = 3'b010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        LOADWAIT = 2'd2,
        RESP     = 2'd3
    } lsu_state_t;

    // Request fields captured at the handshake
    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Store funct3 -> dMem write mode; anything not SB/SH falls back to word
    function automatic logic [2:0] store_wmode(input logic [2:0] f3);
        case (f3)
            F3_B:    return WMODE_BU;
            F3_H:    return WMODE_HU;
            default: return WMODE_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data extraction: byte/halfword sign or zero extension of the
// little-endian word returned by dMem (byte at the request address in [7:0]).
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_word,
    output logic [31:0] o_result
);

    // Select width and extension from funct3
    always_comb begin
        o_result = i_word;
        case (i_funct3)
            F3_B:    o_result = {{24{i_word[7]}}, i_word[7:0]};
            F3_BU:   o_result = {24'd0, i_word[7:0]};
            F3_H:    o_result = {{16{i_word[15]}}, i_word[15:0]};
            F3_HU:   o_result = {16'd0, i_word[15:0]};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of the RV32I data memory. One request at a
// time: check, drive dMem, return a single-cycle response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [2:0]  reqFunct3,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        rspValid,
    output logic [31:0] rspRData,
    output logic        rspErr,
    output logic        memWE,
    output logic [2:0]  memWMode,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic [31:0] memRData
);

    lsu_state_t  r_state, w_next;
    lsu_req_t    r_req;
    logic [2:0]  r_wmode;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_hs;
    logic        w_legal_f3;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_err;
    logic [31:0] w_size;
    logic [31:0] w_limit;
    logic [31:0] w_ext;

    assign w_hs = reqValid && reqReady;

    // Request checks: funct3 legality, natural alignment, range without wrap
    always_comb begin
        if (reqWrite)
            w_legal_f3 = (reqFunct3 == F3_B) || (reqFunct3 == F3_H) || (reqFunct3 == F3_W);
        else
            w_legal_f3 = (reqFunct3 == F3_B) || (reqFunct3 == F3_H) || (reqFunct3 == F3_W) ||
                         (reqFunct3 == F3_BU) || (reqFunct3 == F3_HU);
        w_misaligned = ((reqFunct3[1:0] == 2'b01) && reqAddr[0]) ||
                       ((reqFunct3[1:0] == 2'b10) && (reqAddr[1:0] != 2'b00));
        // loads always pull a full word out of dMem, so they need 4 bytes of room
        if (!reqWrite || (reqFunct3[1:0] == 2'b10))
            w_size = 32'd4;
        else if (reqFunct3[1:0] == 2'b01)
            w_size = 32'd2;
        else
            w_size = 32'd1;
        w_limit        = 32'(MEM_BYTES) - w_size;
        w_out_of_range = reqAddr > w_limit;
        w_err          = !w_legal_f3 || w_misaligned || w_out_of_range;
    end

    lsu_load_extend u_ext (
        .i_funct3 (r_req.funct3),
        .i_word   (memRData),
        .o_result (w_ext)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // FSM next state and state-decoded outputs; memWE follows reset asynchronously
    always_comb begin
        w_next   = r_state;
        reqReady = 1'b0;
        rspValid = 1'b0;
        memWE    = 1'b0;
        case (r_state)
            IDLE: begin
                reqReady = 1'b1;
                if (w_hs)
                    w_next = w_err ? RESP : ACCESS;
            end
            ACCESS: begin
                memWE  = r_req.write;
                w_next = r_req.write ? RESP : LOADWAIT;
            end
            LOADWAIT: w_next = RESP;
            RESP: begin
                rspValid = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch at handshake; load result captured at the end of LOADWAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req   <= '0;
            r_wmode <= WMODE_W;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (w_hs) begin
            r_req.write  <= reqWrite;
            r_req.funct3 <= reqFunct3;
            r_req.addr   <= reqAddr;
            r_req.wdata  <= reqWData;
            r_wmode      <= store_wmode(reqFunct3);
            r_err        <= w_err;
            r_rdata      <= '0;
        end else if (r_state == LOADWAIT) begin
            r_rdata <= w_ext;
        end
    end

    assign memAddr  = r_req.addr;
    assign memWData = r_req.wdata;
    assign memWMode = r_wmode;
    assign rspErr   = r_err;
    assign rspRData = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: dMem model, byte-array scoreboard,
// directed cases then randomized requests.
module tb_load_store_unit;

    localparam int MEMB = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [2:0]  reqFunct3 = 3'd0;
    logic [31:0] reqAddr = 32'd0;
    logic [31:0] reqWData = 32'd0;
    logic        rspValid;
    logic [31:0] rspRData;
    logic        rspErr;
    logic        memWE;
    logic [2:0]  memWMode;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData = 32'd0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEMB)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWData(reqWData),
        .rspValid(rspValid), .rspRData(rspRData), .rspErr(rspErr),
        .memWE(memWE), .memWMode(memWMode), .memAddr(memAddr),
        .memWData(memWData), .memRData(memRData)
    );

    // dMem model: byte-addressed, registered read of 4 bytes starting at memAddr
    logic [7:0] dmem    [0:MEMB-1];
    logic [7:0] ref_mem [0:MEMB-1];

    always @(posedge clk) begin
        int nb;
        longint base;
        base = longint'({32'd0, memAddr});
        if (memWE) begin
            nb = (memWMode == 3'b011) ? 1 : (memWMode == 3'b100) ? 2 : 4;
            for (int k = 0; k < nb; k++)
                if (base + k < MEMB) dmem[base + k] <= memWData[8*k +: 8];
        end
        if (base <= MEMB - 4)
            memRData <= {dmem[base + 3], dmem[base + 2], dmem[base + 1], dmem[base]};
        else
            memRData <= 32'd0;
    end

    // Write-enable monitor
    int          we_cnt = 0;
    logic [2:0]  we_mode;
    logic [31:0] we_addr, we_data;
    always @(negedge clk) begin
        if (memWE) begin
            we_cnt  = we_cnt + 1;
            we_mode = memWMode;
            we_addr = memAddr;
            we_data = memWData;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: is the request rejected?
    function automatic bit ref_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
        longint sz, room;
        bit legal;
        if (w) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
        else   legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        if (!legal) return 1'b1;
        sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        if ({32'd0, a} % sz != 0) return 1'b1;
        room = w ? sz : 4;
        if (longint'({32'd0, a}) > MEMB - room) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: value a legal load returns, from the scoreboard bytes
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        longint v;
        v = 0;
        case (f3)
            0, 4: v = ref_mem[a];
            1, 5: v = ref_mem[a] + 256 * ref_mem[a + 1];
            default: v = ref_mem[a] + 256 * ref_mem[a + 1] + 65536 * ref_mem[a + 2] +
                         16777216 * longint'(ref_mem[a + 3]);
        endcase
        if (f3 == 0 && v >= 128)   v = v - 256;
        if (f3 == 1 && v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    // One request, entered and left at a negedge with the unit idle.
    // hold keeps reqValid high after the handshake (back-to-back traffic).
    task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        bit          e;
        logic [31:0] exp;
        int          lat, n, we0, sz;
        e   = ref_err(w, f3, a);
        exp = (!e && !w) ? ref_load(f3, a) : 32'd0;
        lat = e ? 1 : (w ? 2 : 3);
        n = 0;
        while (!reqReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, reqReady}, 32'd1);
        reqValid  = 1'b1;
        reqWrite  = w;
        reqFunct3 = f3;
        reqAddr   = a;
        reqWData  = d;
        we0 = we_cnt;
        @(posedge clk);
        #1;
        if (!hold) reqValid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk("ready_low_busy", {31'd0, reqReady}, 32'd0);
        end while (!rspValid && n < 10);
        chk("rsp_latency", n, lat);
        chk("rsp_err", {31'd0, rspErr}, {31'd0, e});
        chk("rsp_rdata", rspRData, exp);
        chk("we_pulses", we_cnt - we0, (w && !e) ? 1 : 0);
        if (w && !e) begin
            chk("we_mode", {29'd0, we_mode}, (f3 == 0) ? 32'd3 : (f3 == 1) ? 32'd4 : 32'd2);
            chk("we_addr", we_addr, a);
            chk("we_data", we_data, d);
            sz = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
            for (int k = 0; k < sz; k++) ref_mem[a + k] = 8'((d >> (8 * k)) & 32'hFF);
        end
        @(negedge clk);
        chk("rsp_single_pulse", {31'd0, rspValid}, 32'd0);
        chk("ready_after_rsp", {31'd0, reqReady}, 32'd1);
    endtask

    task automatic chk_reset_outputs;
        chk("rst_ready", {31'd0, reqReady}, 32'd1);
        chk("rst_rspValid", {31'd0, rspValid}, 32'd0);
        chk("rst_rspErr", {31'd0, rspErr}, 32'd0);
        chk("rst_rspRData", rspRData, 32'd0);
        chk("rst_memWE", {31'd0, memWE}, 32'd0);
        chk("rst_memWMode", {29'd0, memWMode}, 32'd2);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_memWData", memWData, 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        bit          w;
        int          r;
        logic [2:0]  lf3 [5];
        lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5;
        for (int i = 0; i < MEMB; i++) begin
            dmem[i]    = 8'd0;
            ref_mem[i] = 8'd0;
        end

        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b1;
        @(negedge clk);

        // directed traffic
        do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        do_req(0, 3'd2, 32'h10, 32'h0, 0);
        do_req(1, 3'd0, 32'h20, 32'h00000080, 0);
        do_req(0, 3'd0, 32'h20, 32'h0, 0);
        do_req(0, 3'd4, 32'h20, 32'h0, 0);
        do_req(1, 3'd1, 32'h22, 32'h00008001, 0);
        do_req(0, 3'd1, 32'h22, 32'h0, 0);
        do_req(0, 3'd5, 32'h22, 32'h0, 0);
        // rejects: misaligned, load past end, illegal funct3, wrapping address
        do_req(0, 3'd1, 32'h21, 32'h0, 0);
        do_req(1, 3'd2, 32'h12, 32'h11111111, 0);
        do_req(0, 3'd2, 32'h3FD, 32'h0, 0);
        do_req(0, 3'd3, 32'h10, 32'h0, 0);
        do_req(1, 3'd4, 32'h10, 32'h0, 0);
        do_req(1, 3'd2, 32'hFFFFFFFC, 32'h22222222, 0);
        do_req(0, 3'd0, 32'h3FD, 32'h0, 0);
        // range edges
        do_req(1, 3'd0, 32'h3FF, 32'h000000A5, 0);
        do_req(1, 3'd1, 32'h3FE, 32'h00001234, 0);
        do_req(1, 3'd2, 32'h400, 32'h33333333, 0);
        do_req(1, 3'd2, 32'h3FC, 32'hA1B2C3D4, 0);
        do_req(0, 3'd2, 32'h3FC, 32'h0, 0);

        // back-to-back with reqValid held high
        do_req(1, 3'd2, 32'h100, 32'hCAFEF00D, 1);
        do_req(0, 3'd2, 32'h100, 32'h0, 1);
        do_req(0, 3'd5, 32'h102, 32'h0, 1);
        do_req(1, 3'd1, 32'h101, 32'h0, 1);
        do_req(0, 3'd0, 32'h103, 32'h0, 1);
        reqValid = 1'b0;

        // randomized requests
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                f3 = w ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
            else
                f3 = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            if (r <= 6)      a = 32'($urandom_range(0, MEMB - 1));
            else if (r == 7) a = 32'($urandom_range(MEMB - 8, MEMB - 1));
            else if (r == 8) a = $urandom;
            else             a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
            do_req(w, f3, a, $urandom, 0);
        end

        // reset during the ACCESS cycle of a store
        reqValid  = 1'b1;
        reqWrite  = 1'b1;
        reqFunct3 = 3'd2;
        reqAddr   = 32'h40;
        reqWData  = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        chk("we_in_access", {31'd0, memWE}, 32'd1);
        #1 rst = 1'b0;
        #1 chk("we_async_drop", {31'd0, memWE}, 32'd0);
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, rspValid}, 32'd0);
            chk("abort_ready", {31'd0, reqReady}, 32'd1);
        end
        do_req(0, 3'd2, 32'h40, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
